// File: rtl/mix_cic_decim_pkg.sv
// Shared constants and width helpers for the 2nd-order CIC decimator.
// Accumulator width grows by one LOG2R per integrator stage.
package mix_cic_decim_pkg;

  localparam int CIC_ORDER = 2;
  localparam int DIN_W_DEF = 20;
  localparam int LOG2R_DEF = 3;

  function automatic int acc_w(input int din_w, input int log2r);
    return din_w + CIC_ORDER * log2r;
  endfunction

  function automatic int out_sh(input int log2r);
    return CIC_ORDER * log2r;
  endfunction

endpackage

// File: rtl/mix_cic_decim_comb.sv
// Registered differentiator y = x - x_prev, advancing only when en is high.
module mix_cic_decim_comb
  import mix_cic_decim_pkg::*;
#(
  parameter int W = acc_w(DIN_W_DEF, LOG2R_DEF)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  logic [W-1:0] d_reg;
  logic [W-1:0] y_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_reg <= '0;
      y_reg <= '0;
    end else if (en) begin
      y_reg <= x - d_reg;
      d_reg <= x;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/mix_cic_decim.sv
// 2nd-order CIC decimator, R = 2**LOG2R, unity DC gain with round-half-up.
// Integrators wrap modulo 2**ACC_W by design; comb stages run at the decimated rate.
module mix_cic_decim
  import mix_cic_decim_pkg::*;
#(
  parameter int DIN_W = DIN_W_DEF,
  parameter int LOG2R = LOG2R_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din_valid,
  input  logic [DIN_W-1:0] din,
  input  logic             sync,
  output logic [DIN_W-1:0] dout,
  output logic             dout_valid,
  output logic [LOG2R-1:0] phase
);

  localparam int ACC_W = acc_w(DIN_W, LOG2R);
  localparam int SH    = out_sh(LOG2R);

  localparam logic [LOG2R-1:0] CNT_LAST = '1;
  localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (SH - 1);

  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] i1_reg;
  logic [ACC_W-1:0] i2_reg;
  logic [LOG2R-1:0] cnt_reg;
  logic [LOG2R-1:0] cnt_next;
  logic             dec_stb_reg;
  logic [2:0]       stb_pipe_reg;
  logic [ACC_W-1:0] comb_x [CIC_ORDER];
  logic [ACC_W-1:0] comb_y [CIC_ORDER];
  logic [CIC_ORDER-1:0] comb_en;
  logic [ACC_W-1:0] rnd_sum;
  logic [DIN_W-1:0] rnd_reg;
  logic [DIN_W-1:0] dout_reg;
  logic             dout_valid_reg;
  logic             unused_round_bits;

  assign din_ext = {{SH{din[DIN_W-1]}}, din};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i1_reg <= '0;
      i2_reg <= '0;
    end else if (din_valid) begin
      i1_reg <= i1_reg + din_ext;
      i2_reg <= i2_reg + i1_reg;
    end
  end

  // sync makes the sample accepted alongside it phase 0 of a fresh block
  always_comb begin
    cnt_next = cnt_reg;
    if (sync) begin
      cnt_next = din_valid ? LOG2R'(1) : '0;
    end else if (din_valid) begin
      cnt_next = cnt_reg + LOG2R'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      dec_stb_reg  <= 1'b0;
      stb_pipe_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      dec_stb_reg  <= din_valid && !sync && (cnt_reg == CNT_LAST);
      stb_pipe_reg <= {stb_pipe_reg[1:0], dec_stb_reg};
    end
  end

  assign comb_en = {stb_pipe_reg[0], dec_stb_reg};

  generate
    for (genvar gi = 0; gi < CIC_ORDER; gi++) begin : g_comb
      if (gi == 0) begin : g_first
        assign comb_x[gi] = i2_reg;
      end else begin : g_chain
        assign comb_x[gi] = comb_y[gi-1];
      end

      mix_cic_decim_comb #(
        .W (ACC_W)
      ) u_comb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (comb_en[gi]),
        .x       (comb_x[gi]),
        .y       (comb_y[gi])
      );
    end
  endgenerate

  // Rounding add is registered separately from the output register
  assign rnd_sum           = comb_y[CIC_ORDER-1] + HALF;
  assign unused_round_bits = ^rnd_sum[SH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnd_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (stb_pipe_reg[1]) begin
        rnd_reg <= rnd_sum[ACC_W-1:SH];
      end
      if (stb_pipe_reg[2]) begin
        dout_reg <= rnd_reg;
      end
      dout_valid_reg <= stb_pipe_reg[2];
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign phase      = cnt_reg;

endmodule

// File: tb/tb_mix_cic_decim.sv
// Bench for mix_cic_decim: closed-form CIC reference computed from the accepted-sample history.
module tb_mix_cic_decim;

  localparam int DIN_W = 20;
  localparam int LOG2R = 3;
  localparam int R     = 8;
  localparam int SH    = 6;

  logic             clk       = 1'b0;
  logic             reset_n   = 1'b1;
  logic             din_valid = 1'b0;
  logic [DIN_W-1:0] din       = '0;
  logic             sync      = 1'b0;
  logic [DIN_W-1:0] dout;
  logic             dout_valid;
  logic [LOG2R-1:0] phase;

  always #5 clk = ~clk;

  mix_cic_decim #(
    .DIN_W (DIN_W),
    .LOG2R (LOG2R)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din_valid  (din_valid),
    .din        (din),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .phase      (phase)
  );

  typedef struct {
    int               due;
    logic [DIN_W-1:0] val;
  } exp_t;

  int     errors = 0;
  int     checks = 0;
  longint hist[$];
  int     bnd_n[$];
  exp_t   expq[$];
  int     cyc = 0;
  int     blk = 0;
  bit     sync_seen = 0;
  logic [DIN_W-1:0] last_dout = '0;
  int     last_vcyc = -1;
  int     prev_vcyc = -1;
  int     nvalid = 0;
  int     nseen = 0;

  function automatic logic [63:0] sx(input logic [DIN_W-1:0] v);
    return {{(64-DIN_W){v[DIN_W-1]}}, v};
  endfunction

  // i2 after n accepted samples: sum_j x_j * (n-1-j)
  function automatic longint vsum(input int n);
    longint s = 0;
    for (int j = 0; j < n - 1; j++) s += hist[j] * longint'(n - 1 - j);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_edge(input logic v, input logic [DIN_W-1:0] x, input logic s);
    bit     bnd;
    int     k;
    longint v0, v1, v2, c2, q;
    logic [DIN_W-1:0] val;
    cyc++;
    if (v) begin
      bnd = !s && ((blk % R) == R - 1);
      hist.push_back(longint'($signed(x)));
      blk = s ? 1 : blk + 1;
      if (bnd) begin
        bnd_n.push_back(hist.size());
        k  = bnd_n.size();
        v0 = vsum(bnd_n[k-1]);
        v1 = (k >= 2) ? vsum(bnd_n[k-2]) : 0;
        v2 = (k >= 3) ? vsum(bnd_n[k-3]) : 0;
        c2 = v0 - 2 * v1 + v2;
        if (!sync_seen) begin
          check("c2_range", 64'((c2 <= 64'sd33554432 && c2 >= -64'sd33554432) ? 1 : 0), 64'd1);
        end
        q   = (c2 + (64'sd1 <<< (SH - 1))) >>> SH;
        val = q[DIN_W-1:0];
        expq.push_back('{cyc + 4, val});
      end
    end else if (s) begin
      blk = 0;
    end
    if (s) sync_seen = 1;
  endtask

  task automatic observe();
    bit exp_v;
    while (expq.size() > 0 && expq[0].due < cyc) void'(expq.pop_front());
    exp_v = (expq.size() > 0) && (expq[0].due == cyc);
    if (dout_valid === 1'b1) nseen++;
    check("dout_valid", 64'(dout_valid), 64'(exp_v));
    if (exp_v) begin
      check("dout", sx(dout), sx(expq[0].val));
      $display("out cyc=%0d dout=%0d expected=%0d phase=%0d", cyc, $signed(dout),
               $signed(expq[0].val), phase);
      void'(expq.pop_front());
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      last_dout = dout;
      nvalid++;
    end
    check("phase", 64'(phase), 64'(blk % R));
  endtask

  task automatic step(input logic v, input logic [DIN_W-1:0] x, input logic s);
    din_valid = v;
    din       = x;
    sync      = s;
    @(posedge clk);
    model_edge(v, x, s);
    #1;
    observe();
  endtask

  task automatic do_reset(input int hold);
    din_valid = 1'b0;
    sync      = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_dout", sx(dout), 64'd0);
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_phase", 64'(phase), 64'd0);
    hist.delete();
    bnd_n.delete();
    expq.delete();
    blk       = 0;
    sync_seen = 0;
    repeat (hold) begin
      @(posedge clk);
      cyc++;
    end
    #3 reset_n = 1'b1;
  endtask

  task automatic run_dc(input int x, input int nblk, input bit gapped);
    int n0 = nvalid;
    for (int i = 0; i < nblk * R; i++) begin
      step(1'b1, DIN_W'(x), 1'b0);
      if (gapped) step(1'b0, DIN_W'(x), 1'b0);
    end
    repeat (5) step(1'b0, DIN_W'(x), 1'b0);
    check($sformatf("dc_%0d", x), sx(last_dout), 64'(x));
    check("dc_count", 64'(nvalid - n0), 64'(nblk));
    check("dc_spacing", 64'(last_vcyc - prev_vcyc), gapped ? 64'd16 : 64'd8);
  endtask

  initial begin
    int tone[4];
    int d;
    int sync_edge;
    int first_v;
    int sz;
    int n0;
    logic v;

    tone = '{261121, 130560, 0, 130560};

    do_reset(2);

    run_dc(1000, 6, 1'b0);
    run_dc(-1000, 6, 1'b0);
    run_dc(-524288, 6, 1'b0);
    run_dc(524287, 6, 1'b0);

    for (int i = 0; i < 8 * R; i++) step(1'b1, DIN_W'(tone[i % 4]), 1'b0);
    repeat (5) step(1'b0, '0, 1'b0);
    d = $signed(last_dout) - 130560;
    check("tone_dc_1lsb", 64'((d >= -1 && d <= 1) ? 1 : 0), 64'd1);

    run_dc(500, 6, 1'b1);

    for (int i = 0; i < 300; i++) begin
      v = ($urandom % 4) != 0;
      step(v, DIN_W'($urandom), 1'b0);
    end
    for (int i = 0; i < 200; i++) begin
      v = ($urandom % 4) != 0;
      step(v, DIN_W'($urandom), ($urandom % 16) == 0);
    end
    repeat (5) step(1'b0, '0, 1'b0);

    do_reset(1);
    for (int i = 0; i < 2 * R + 5; i++) step(1'b1, DIN_W'(200), 1'b0);
    step(1'b1, DIN_W'(200), 1'b1);
    check("sync_phase", 64'(phase), 64'd1);
    sync_edge = cyc;
    first_v   = -1;
    for (int i = 0; i < 20 && first_v < 0; i++) begin
      step(1'b1, DIN_W'(200), 1'b0);
      if (dout_valid === 1'b1) first_v = cyc;
    end
    check("sync_latency", 64'(first_v - sync_edge), 64'd11);

    for (int i = 0; i < 20; i++) begin
      sz = expq.size();
      step(1'b1, DIN_W'(-3000), 1'b0);
      if (expq.size() > sz) break;
    end
    step(1'b1, DIN_W'(-3000), 1'b0);
    do_reset(1);
    n0 = nseen;
    for (int i = 0; i < R + 3; i++) step(1'b1, DIN_W'(-3000), 1'b0);
    check("no_stale", 64'(nseen - n0), 64'd0);
    step(1'b1, DIN_W'(-3000), 1'b0);
    check("first_after_rst", 64'(dout_valid), 64'd1);
    repeat (5) step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
